// File: rtl/z80_ram_arbiter.sv
// ============================================================================
// z80_ram_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one single-port synchronous 64Kx8 RAM between the gate-level Z80
//   bus and a host loader/debug port. The Z80 always has priority. The host
//   is only serviced while the Z80 is not in a memory cycle (_z_mreq high).
//   Each Z80 memory cycle produces exactly one RAM access. Refresh cycles
//   never touch the RAM. All Z80 pad signals are eclk-synchronous, so the
//   inputs are used directly without synchronizers.
//
// Configuration macro:
//   Z80_RAM_WPROT_EN - when defined, Z80 writes below ROM_TOP are dropped.
//                      The Z80 cycle is still consumed, and wp_hits counts
//                      the dropped writes, saturating at 16'hFFFF. Host
//                      writes are never protected. When the macro is
//                      undefined, wp_hits is tied to zero.
//
// Parameters:
//   AW      - address width
//   DW      - data width
//   ROM_TOP - first writable Z80 address when write protection is built
//
// Ports:
//   eclk      in   emulation clock, the only clock
//   _erst     in   asynchronous active-low reset
//   z_ab      in   Z80 address pads
//   z_dout    in   Z80 write data
//   _z_mreq   in   Z80 memory request (active low)
//   _z_rd     in   Z80 read strobe (active low)
//   _z_wr     in   Z80 write strobe (active low)
//   _z_rfsh   in   Z80 refresh (active low)
//   z_din     out  registered read data to the Z80 data bus
//   h_req     in   host request level, held until h_ack
//   h_we      in   host write (1) / read (0)
//   h_addr    in   host address
//   h_wdata   in   host write data
//   h_ack     out  one-cycle host completion pulse
//   h_rdata   out  host read data, valid with h_ack and held afterwards
//   ram_a     out  RAM address
//   ram_din   out  RAM write data
//   ram_we    out  RAM write enable, one eclk pulse
//   ram_dout  in   RAM read data, valid 1 eclk after the address is presented
//   busy      out  FSM not in IDLE
//   wp_hits   out  count of protected Z80 writes (0 when the feature is off)
// ============================================================================
module z80_ram_arbiter #(
    parameter int unsigned   AW      = 16,
    parameter int unsigned   DW      = 8,
    parameter logic [AW-1:0] ROM_TOP = 16'h2000
) (
    input  logic          eclk,
    input  logic          _erst,

    // Z80 bus
    input  logic [AW-1:0] z_ab,
    input  logic [DW-1:0] z_dout,
    input  logic          _z_mreq,
    input  logic          _z_rd,
    input  logic          _z_wr,
    input  logic          _z_rfsh,
    output logic [DW-1:0] z_din,

    // Host loader/debug port
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic [DW-1:0] h_rdata,

    // RAM port
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,

    // Status
    output logic          busy,
    output logic [15:0]   wp_hits
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_Z_WAIT,
        ST_H_WAIT
    } state_e;

    state_e        state_q;
    logic          z_served_q;
    logic [AW-1:0] ram_a_q;
    logic [DW-1:0] ram_din_q;
    logic          ram_we_q;
    logic [DW-1:0] z_din_q;
    logic          h_ack_q;
    logic [DW-1:0] h_rdata_q;

    // A Z80 memory cycle needs service once its strobe is active. During a
    // write cycle, _z_rd stays high, so the request waits for _z_wr to fall,
    // when z_dout is already stable. z_served blocks a second access within
    // the same cycle.
    logic z_pend;
    assign z_pend = ~_z_mreq & _z_rfsh & (~_z_rd | ~_z_wr) & ~z_served_q;

    // The host is never granted inside a Z80 memory cycle, refresh included.
    logic h_grant;
    assign h_grant = h_req & _z_mreq;

    // A Z80 write is being issued this cycle.
    logic z_wr_issue;
    assign z_wr_issue = (state_q == ST_IDLE) & z_pend & ~_z_wr;

    // ------------------------------------------------------------------------
    // Optional write protection of the low ROM region
    // ------------------------------------------------------------------------
    logic z_wr_blocked;

`ifdef Z80_RAM_WPROT_EN
    logic [15:0] wp_hits_q;
    logic [15:0] wp_hits_d;

    assign z_wr_blocked = (z_ab < ROM_TOP);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wp_hits_d = wp_hits_q;
        if (z_wr_issue && z_wr_blocked && (wp_hits_q != 16'hFFFF)) begin
            wp_hits_d = wp_hits_q + 16'd1;
        end
    end

    always_ff @(posedge eclk or negedge _erst) begin
        if (!_erst) begin
            wp_hits_q <= '0;
        end else begin
            wp_hits_q <= wp_hits_d;
        end
    end

    assign wp_hits = wp_hits_q;
`else
    assign z_wr_blocked = 1'b0;
    assign wp_hits      = '0;

    // ROM_TOP only matters when protection is built.
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
`endif

    // ------------------------------------------------------------------------
    // Arbitration FSM with registered RAM, Z80 and host outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge eclk or negedge _erst) begin
        if (!_erst) begin
            state_q    <= ST_IDLE;
            z_served_q <= 1'b0;
            ram_a_q    <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            z_din_q    <= {DW{1'b1}};
            h_ack_q    <= 1'b0;
            h_rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Where a
            // register gets two assignments in one pass, the later one wins.
            // The pulse defaults below are therefore overridden only in the
            // cycle that raises them.
            ram_we_q <= 1'b0;
            h_ack_q  <= 1'b0;

            // Any eclk outside a memory cycle re-arms Z80 service. z_pend
            // needs _z_mreq low, so this never collides with setting the flag.
            if (_z_mreq) begin
                z_served_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (z_pend) begin
                        ram_a_q    <= z_ab;
                        z_served_q <= 1'b1;
                        if (!_z_wr) begin
                            // A protected write still consumes the cycle.
                            // It just never strobes the RAM.
                            ram_din_q <= z_dout;
                            ram_we_q  <= ~z_wr_blocked;
                        end else begin
                            state_q <= ST_Z_WAIT;
                        end
                    end else if (h_grant) begin
                        ram_a_q <= h_addr;
                        if (h_we) begin
                            ram_din_q <= h_wdata;
                            ram_we_q  <= 1'b1;
                            h_ack_q   <= 1'b1;
                        end else begin
                            state_q <= ST_H_WAIT;
                        end
                    end
                end

                ST_Z_WAIT: begin
                    z_din_q <= ram_dout;
                    state_q <= ST_IDLE;
                end

                ST_H_WAIT: begin
                    h_rdata_q <= ram_dout;
                    h_ack_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_a   = ram_a_q;
    assign ram_din = ram_din_q;
    assign ram_we  = ram_we_q;
    assign z_din   = z_din_q;
    assign h_ack   = h_ack_q;
    assign h_rdata = h_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
